fifo_frame_write: RTL

//  Frame serializer: on an fs/fd start-done handshake, latches a wide parallel word and writes it into
//  the byte-wide FIFO write port, most-significant byte first (byte 0 = din[8*MAX_LEN-1 -: 8]).

---
 rtl/fifo_frame_write.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo_frame_write.sv
// rtl/fifo_frame_write.sv - word-to-byte frame serializer into a FIFO write port, MSB first
// Optional FIFO_FRAME_CSUM_EN appends an XOR checksum byte after the payload.
module fifo_frame_write #(
  parameter int MAX_LEN = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fs,
  output logic                 fd,
  input  logic [11:0]          data_len,
  input  logic [8*MAX_LEN-1:0] din,
  input  logic                 fifo_full,
  output logic [7:0]           fifo_txd,
  output logic                 fifo_txen,
  output logic                 err
);

  localparam int W = 8 * MAX_LEN;

`ifdef FIFO_FRAME_CSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WORK, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WORK, DONE} state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [11:0]    cnt_q, cnt_d;
  logic           fd_q, fd_d;
  logic [7:0]     txd_q, txd_d;
  logic           len_bad;
`ifdef FIFO_FRAME_CSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  assign len_bad = (data_len == 12'd0) || (data_len > 12'(MAX_LEN));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    fifo_txen = 1'b0;
    fifo_txd  = txd_q;
    err       = 1'b0;
`ifdef FIFO_FRAME_CSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE: if (fs) state_d = LOAD;
      LOAD: begin
        shift_d = din;
        cnt_d   = data_len;
`ifdef FIFO_FRAME_CSUM_EN
        csum_d  = 8'd0;
`endif
        if (len_bad) begin
          err     = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WORK;
        end
      end
      WORK: begin
        fifo_txd  = shift_q[W-1 -: 8];
        fifo_txen = ~fifo_full;
        if (fifo_txen) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q - 12'd1;
`ifdef FIFO_FRAME_CSUM_EN
          csum_d  = csum_q ^ shift_q[W-1 -: 8];
          if (cnt_q == 12'd1) state_d = CSUM;
`else
          if (cnt_q == 12'd1) state_d = DONE;
`endif
        end
      end
`ifdef FIFO_FRAME_CSUM_EN
      CSUM: begin
        fifo_txd  = csum_q;
        fifo_txen = ~fifo_full;
        if (fifo_txen) state_d = DONE;
      end
`endif
      DONE: if (!fs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // fd is a registered image of being in DONE; txd holds whatever was last presented
    fd_d  = (state_d == DONE);
    txd_d = fifo_txd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      txd_q   <= 8'd0;
`ifdef FIFO_FRAME_CSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      txd_q   <= txd_d;
`ifdef FIFO_FRAME_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign fd = fd_q;

endmodule
